// File: rtl/riscv_pipe_ctrl.sv
// RISC-V pipeline controller: decodes in D and carries control through E/M/W.
// Branch/jump resolution happens in E from the registered bundle and ALU flags.
module riscv_pipe_ctrl #(
  parameter bit EN_M  = 1'b0,
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             flushE,
  input  logic             zeroE,
  input  logic             ltE,
  output logic [2:0]       immSrcD,
  output logic             regWriteE,
  output logic             regWriteM,
  output logic             regWriteW,
  output logic [1:0]       resultSrcE,
  output logic [1:0]       resultSrcM,
  output logic [1:0]       resultSrcW,
  output logic             memWriteM,
  output logic [ALU_W-1:0] ALUControlE,
  output logic             ALUSrcE,
  output logic [1:0]       pcSrcE,
  output logic             illegalW
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic             rw;
    logic [1:0]       rs;
    logic             mw;
    logic [ALU_W-1:0] alu;
    logic             asrc;
    logic [2:0]       br;
    logic [1:0]       jmp;
    logic             ill;
  } ex_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       ill;
  } mem_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       ill;
  } wb_t;

  ex_t        dec;
  logic [2:0] imm;
  logic [3:0] alu4;
  logic [3:0] base;
  logic       base_ok;
  logic       ok;

  ex_t  e_q, e_d;
  mem_t m_q, m_d;
  wb_t  w_q, w_d;

  // Shared R/I-type func3 to ALU op mapping
  always_comb begin
    base    = 4'd0;
    base_ok = 1'b1;
    case (func3)
      3'b000:  base = 4'd0;
      3'b111:  base = 4'd2;
      3'b110:  base = 4'd3;
      3'b100:  base = 4'd4;
      3'b010:  base = 4'd5;
      3'b011:  base = 4'd6;
      3'b001:  base = 4'd7;
      default: base_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec  = '0;
    imm  = 3'b000;
    alu4 = 4'd0;
    ok   = 1'b0;
    case (op)
      OP_R: begin
        dec.rw = 1'b1;
        if (func7 == 7'b0000000) begin
          ok   = base_ok;
          alu4 = base;
        end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
          ok   = 1'b1;
          alu4 = 4'd1;
        end else if (func7 == 7'b0000001 && EN_M) begin
          ok = 1'b1;
          case (func3)
            3'b000:  alu4 = 4'd8;
            3'b001:  alu4 = 4'd9;
            3'b100:  alu4 = 4'd10;
            3'b110:  alu4 = 4'd11;
            default: ok = 1'b0;
          endcase
        end
      end
      OP_I: begin
        dec.rw   = 1'b1;
        dec.asrc = 1'b1;
        alu4     = base;
        ok       = base_ok && (func3 != 3'b001 || func7 == 7'b0000000);
      end
      OP_LD: begin
        ok       = (func3 == 3'b010);
        dec.rw   = 1'b1;
        dec.rs   = 2'b01;
        dec.asrc = 1'b1;
      end
      OP_ST: begin
        ok       = (func3 == 3'b010);
        dec.mw   = 1'b1;
        dec.asrc = 1'b1;
        imm      = 3'b001;
      end
      OP_BR: begin
        ok   = 1'b1;
        imm  = 3'b010;
        case (func3)
          3'b000:  begin dec.br = 3'd1; alu4 = 4'd1; end
          3'b001:  begin dec.br = 3'd2; alu4 = 4'd1; end
          3'b100:  begin dec.br = 3'd3; alu4 = 4'd5; end
          3'b101:  begin dec.br = 3'd4; alu4 = 4'd5; end
          3'b110:  begin dec.br = 3'd3; alu4 = 4'd6; end
          3'b111:  begin dec.br = 3'd4; alu4 = 4'd6; end
          default: ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        ok      = 1'b1;
        dec.rw  = 1'b1;
        dec.rs  = 2'b10;
        dec.jmp = 2'b01;
        imm     = 3'b011;
      end
      OP_JALR: begin
        ok       = (func3 == 3'b000);
        dec.rw   = 1'b1;
        dec.rs   = 2'b10;
        dec.asrc = 1'b1;
        dec.jmp  = 2'b10;
      end
      OP_LUI: begin
        ok     = 1'b1;
        dec.rw = 1'b1;
        dec.rs = 2'b11;
        imm    = 3'b100;
      end
      default: ok = 1'b0;
    endcase
    dec.alu = ALU_W'(alu4);
    if (!ok) begin
      dec     = '0;
      dec.ill = 1'b1;
      imm     = 3'b000;
    end
  end

  always_comb begin
    e_d = flushE ? '0 : dec;
    m_d = '{rw: e_q.rw, rs: e_q.rs, mw: e_q.mw, ill: e_q.ill};
    w_d = '{rw: m_q.rw, rs: m_q.rs, ill: m_q.ill};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  always_comb begin
    pcSrcE = 2'b00;
    if (e_q.jmp == 2'b10) pcSrcE = 2'b10;
    else if (e_q.jmp == 2'b01) pcSrcE = 2'b01;
    else begin
      case (e_q.br)
        3'd1:    if (zeroE)  pcSrcE = 2'b01;
        3'd2:    if (!zeroE) pcSrcE = 2'b01;
        3'd3:    if (ltE)    pcSrcE = 2'b01;
        3'd4:    if (!ltE)   pcSrcE = 2'b01;
        default: pcSrcE = 2'b00;
      endcase
    end
  end

  assign immSrcD     = imm;
  assign regWriteE   = e_q.rw;
  assign resultSrcE  = e_q.rs;
  assign ALUControlE = e_q.alu;
  assign ALUSrcE     = e_q.asrc;
  assign regWriteM   = m_q.rw;
  assign resultSrcM  = m_q.rs;
  assign memWriteM   = m_q.mw;
  assign regWriteW   = w_q.rw;
  assign resultSrcW  = w_q.rs;
  assign illegalW    = w_q.ill;

endmodule
